core_control: RTL and testbench

Multi-cycle sequencer for the mriscv core. It steps each instruction through fetch, decode, execute, optional memory access and writeback by asserting one stage-enable strobe per state. It arbitrates the single memory port between instruction fetch and load/store, with a wait-state timeout. It also maintains cycle and retired-instruction counters. It sits beside the `execute` datapath and drives its enables, the register-file write enable and the PC write enable.

---
 rtl/core_control_pkg.sv | 21 ++
 rtl/wait_timer.sv | 33 +++
 rtl/core_control.sv | 99 +++++++++
 tb/tb_core_control.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/core_control_pkg.sv
// Shared definitions for the mriscv multi-cycle sequencer:
// state encodings and the default memory wait-state limit.
package core_control_pkg;

   typedef enum logic [2:0] {
      ST_START     = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEMORY    = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_TRAP      = 3'd6
   } state_t;

   localparam int TIMEOUT_DEF = 16;

   function automatic logic is_wait_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEMORY);
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory wait-state timer shared by FETCH and MEMORY.
// expired flags the last permitted wait cycle; TIMEOUT=0 never expires.
module wait_timer
   import core_control_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;
   localparam logic ENABLED = (TIMEOUT > 0);

   logic [W-1:0] count;

   assign expired = ENABLED && (count == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/core_control.sv
// Multi-cycle instruction sequencer: stage strobes, memory-port
// arbitration with wait-state timeout, cycle and instret counters.
module core_control
   import core_control_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_ready,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             is_branch,
   input  logic             illegal,
   output logic             instr_req,
   output logic             decode_en,
   output logic             execute_en,
   output logic             data_req,
   output logic             data_we,
   output logic             reg_we,
   output logic             pc_we,
   output logic             trapped,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instret
);

   state_t state, next;
   logic   load_q, store_q, wb_q;
   logic   expired;

   wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (!is_wait_state(state)),
      .count_en (is_wait_state(state) && !mem_ready),
      .expired  (expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_START;
      else       state <= next;
   end

   // mem_ready takes priority over an expiring timer
   always_comb begin
      next = state;
      unique case (state)
         ST_START:     next = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready)    next = ST_DECODE;
            else if (expired) next = ST_TRAP;
         end
         ST_DECODE:    next = illegal ? ST_TRAP : ST_EXECUTE;
         ST_EXECUTE:   next = (load_q || store_q) ? ST_MEMORY
                                                  : ST_WRITEBACK;
         ST_MEMORY: begin
            if (mem_ready)    next = ST_WRITEBACK;
            else if (expired) next = ST_TRAP;
         end
         ST_WRITEBACK: next = ST_FETCH;
         ST_TRAP:      next = ST_TRAP;
         default:      next = ST_START;
      endcase
   end

   // a load+store decode collapses to a store
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_q  <= 1'b0;
         store_q <= 1'b0;
         wb_q    <= 1'b0;
      end else if (state == ST_DECODE) begin
         load_q  <= is_load & ~is_store;
         store_q <= is_store;
         wb_q    <= ~(is_branch | is_store);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_count <= '0;
         instret     <= '0;
      end else begin
         cycle_count <= cycle_count + 1'b1;
         if (state == ST_WRITEBACK) instret <= instret + 1'b1;
      end
   end

   assign instr_req  = (state == ST_FETCH);
   assign decode_en  = (state == ST_DECODE);
   assign execute_en = (state == ST_EXECUTE);
   assign data_req   = (state == ST_MEMORY);
   assign data_we    = (state == ST_MEMORY) && store_q;
   assign pc_we      = (state == ST_WRITEBACK);
   assign reg_we     = (state == ST_WRITEBACK) && wb_q;
   assign trapped    = (state == ST_TRAP);

endmodule

// File: tb/tb_core_control.sv
// Scoreboard bench for core_control: directed per-cycle vectors
// push expected outputs; a negedge monitor pops and compares.
module tb_core_control;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mem_ready = 1'b0;
   logic       is_load = 1'b0;
   logic       is_store = 1'b0;
   logic       is_branch = 1'b0;
   logic       illegal = 1'b0;
   logic       instr_req, decode_en, execute_en, data_req;
   logic       data_we, reg_we, pc_we, trapped;
   logic [7:0] cycle_count, instret;

   core_control #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_ready   (mem_ready),
      .is_load     (is_load),
      .is_store    (is_store),
      .is_branch   (is_branch),
      .illegal     (illegal),
      .instr_req   (instr_req),
      .decode_en   (decode_en),
      .execute_en  (execute_en),
      .data_req    (data_req),
      .data_we     (data_we),
      .reg_we      (reg_we),
      .pc_we       (pc_we),
      .trapped     (trapped),
      .cycle_count (cycle_count),
      .instret     (instret)
   );

   always #5 clk = ~clk;

   // strobe vector order: instr_req decode_en execute_en data_req
   //                      data_we reg_we pc_we trapped
   localparam logic [7:0] Z  = 8'h00;
   localparam logic [7:0] F  = 8'h80;
   localparam logic [7:0] D  = 8'h40;
   localparam logic [7:0] E  = 8'h20;
   localparam logic [7:0] ML = 8'h10;
   localparam logic [7:0] MS = 8'h18;
   localparam logic [7:0] WR = 8'h06;
   localparam logic [7:0] WN = 8'h02;
   localparam logic [7:0] T  = 8'h01;

   typedef struct packed {
      logic [7:0] strb;
      logic [7:0] iret;
      logic [7:0] cyc;
   } exp_t;

   exp_t       sb[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] cyc_model = 8'd0;

   task automatic vec(input logic r, input logic rdy, input logic ld,
                      input logic st, input logic br, input logic il,
                      input logic [7:0] strb, input logic [7:0] iret);
      exp_t e;
      @(posedge clk);
      #1;
      reset     = r;
      mem_ready = rdy;
      is_load   = ld;
      is_store  = st;
      is_branch = br;
      illegal   = il;
      e.strb = strb;
      e.iret = iret;
      if (r) begin
         e.cyc     = 8'd0;
         cyc_model = 8'd0;
      end else begin
         e.cyc     = cyc_model;
         cyc_model = cyc_model + 8'd1;
      end
      sb.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t       e;
      logic [7:0] act;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         act = {instr_req, decode_en, execute_en, data_req,
                data_we, reg_we, pc_we, trapped};
         vectors++;
         if (act !== e.strb || instret !== e.iret ||
             cycle_count !== e.cyc) begin
            miscompares++;
            $display("FAIL vec%0d: got strobes=%b instret=%0d cycle=%0d, want strobes=%b instret=%0d cycle=%0d",
                     vectors, act, instret, cycle_count,
                     e.strb, e.iret, e.cyc);
         end
      end
   end

   initial begin
      int waits;
      // reset held 3 cycles, then START and first fetch
      repeat (3) vec(1, 0, 0, 0, 0, 0, Z, 0);
      vec(0, 1, 0, 0, 0, 0, Z, 0);
      // ALU op, zero-wait fetch
      vec(0, 1, 0, 0, 0, 0, F,  0);
      vec(0, 0, 0, 0, 0, 0, D,  0);
      vec(0, 0, 0, 0, 0, 0, E,  0);
      vec(0, 0, 0, 0, 0, 0, WR, 0);
      // store, two memory wait states
      vec(0, 1, 0, 0, 0, 0, F,  1);
      vec(0, 1, 0, 1, 0, 0, D,  1);
      vec(0, 1, 0, 0, 0, 0, E,  1);
      vec(0, 0, 0, 0, 0, 0, MS, 1);
      vec(0, 0, 0, 0, 0, 0, MS, 1);
      vec(0, 1, 0, 0, 0, 0, MS, 1);
      vec(0, 0, 0, 0, 0, 0, WN, 1);
      // branch skips MEMORY, no reg write
      vec(0, 1, 0, 0, 0, 0, F,  2);
      vec(0, 0, 0, 0, 1, 0, D,  2);
      vec(0, 0, 0, 0, 0, 0, E,  2);
      vec(0, 0, 0, 0, 0, 0, WN, 2);
      // load, zero-wait data access
      vec(0, 1, 0, 0, 0, 0, F,  3);
      vec(0, 0, 1, 0, 0, 0, D,  3);
      vec(0, 0, 0, 0, 0, 0, E,  3);
      vec(0, 1, 0, 0, 0, 0, ML, 3);
      vec(0, 0, 0, 0, 0, 0, WR, 3);
      // load and store together act as a store
      vec(0, 1, 0, 0, 0, 0, F,  4);
      vec(0, 0, 1, 1, 0, 0, D,  4);
      vec(0, 0, 0, 0, 0, 0, E,  4);
      vec(0, 1, 0, 0, 0, 0, MS, 4);
      vec(0, 0, 0, 0, 0, 0, WN, 4);
      // mem_ready on the last allowed fetch cycle beats the timeout
      vec(0, 0, 0, 0, 0, 0, F,  5);
      vec(0, 0, 0, 0, 0, 0, F,  5);
      vec(0, 0, 0, 0, 0, 0, F,  5);
      vec(0, 1, 0, 0, 0, 0, F,  5);
      vec(0, 0, 0, 0, 0, 0, D,  5);
      vec(0, 0, 0, 0, 0, 0, E,  5);
      vec(0, 0, 0, 0, 0, 0, WR, 5);
      // illegal in DECODE traps with no pc_we
      vec(0, 1, 0, 0, 0, 0, F,  6);
      vec(0, 0, 0, 0, 0, 1, D,  6);
      repeat (3) vec(0, 1, 0, 0, 0, 1, T, 6);
      // reset during TRAP restarts with counters cleared
      repeat (2) vec(1, 0, 0, 0, 0, 0, Z, 0);
      vec(0, 0, 0, 0, 0, 0, Z, 0);
      // memory timeout after 4 wait cycles
      vec(0, 1, 0, 0, 0, 0, F,  0);
      vec(0, 0, 1, 0, 0, 0, D,  0);
      vec(0, 0, 0, 0, 0, 0, E,  0);
      repeat (4) vec(0, 0, 0, 0, 0, 0, ML, 0);
      repeat (2) vec(0, 1, 0, 0, 0, 0, T,  0);
      // fetch timeout, then long TRAP hold with cycle_count wrap
      vec(1, 0, 0, 0, 0, 0, Z, 0);
      vec(0, 0, 0, 0, 0, 0, Z, 0);
      repeat (4) vec(0, 0, 0, 0, 0, 0, F, 0);
      repeat (270) vec(0, 1, 0, 0, 0, 0, T, 0);
      // reset clears the sticky trap
      vec(1, 0, 0, 0, 0, 0, Z, 0);
      vec(0, 0, 0, 0, 0, 0, Z, 0);
      vec(0, 1, 0, 0, 0, 0, F, 0);

      waits = 0;
      while (sb.size() > 0 && waits < 10) begin
         @(posedge clk);
         waits++;
      end
      if (sb.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected vectors left unchecked, want 0",
                  sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
